// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: bundle of fetch-side and ID-side signals around the fetch queue
//   fetch_issue     PC address accepted by the read adapter (one-cycle pulse)
//   fetch_allow     queue has room for another fetch to be issued
//   inst/inst_addr  returned instruction word and its address, qualified by inst_valid
//   inst_read_ready queue accepts a returned word this cycle
//   flush           branch/exception redirect
//   id_inst/id_pc   head entry, qualified by id_valid, consumed with id_ready
//   master: fetch/ID side driving the queue; slave: the queue itself
interface inst_fetch_queue_if;
   logic        fetch_issue;
   logic        fetch_allow;
   logic [31:0] inst;
   logic [31:0] inst_addr;
   logic        inst_valid;
   logic        inst_read_ready;
   logic        flush;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic        id_valid;
   logic        id_ready;
   modport master (
      output fetch_issue, inst, inst_addr, inst_valid, flush, id_ready,
      input  fetch_allow, inst_read_ready, id_inst, id_pc, id_valid
   );
   modport slave (
      input  fetch_issue, inst, inst_addr, inst_valid, flush, id_ready,
      output fetch_allow, inst_read_ready, id_inst, id_pc, id_valid
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: buffers fetched instruction words with their addresses for the ID stage
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   bus    inst_fetch_queue_if.slave (fetch issue/response side and ID head side)
module inst_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input logic clk,
   input logic reset,
   inst_fetch_queue_if.slave bus
);
   localparam logic [PTR_W:0]   FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PONE = PTR_W'(1);
   localparam logic [PTR_W+1:0] LIM  = (PTR_W+2)'(DEPTH);
   logic [31:0]      inst_mem_q [DEPTH];
   logic [31:0]      pc_mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d, outst_q, outst_d, discard_q, discard_d;
   logic             has, resp, enq, deq, resp_cnt;
   always_comb begin
      has = count_q != '0;
      bus.id_valid = reset && has && !bus.flush;
      bus.id_inst = (reset && has) ? inst_mem_q[rd_ptr_q] : '0;
      bus.id_pc = (reset && has) ? pc_mem_q[rd_ptr_q] : '0;
      // stale responses are always drained, even when the queue is full
      bus.inst_read_ready = reset && (discard_q != '0 || count_q != FULL);
      // entries held plus fetches in flight must never exceed the storage
      bus.fetch_allow = reset && !bus.flush && (({1'b0, count_q} + {1'b0, outst_q}) < LIM);
      resp = bus.inst_valid && bus.inst_read_ready;
      enq = resp && discard_q == '0 && !bus.flush;
      deq = bus.id_valid && bus.id_ready;
      // a response with nothing outstanding is a protocol error and is not counted
      resp_cnt = resp && outst_q != '0;
      outst_d = (bus.fetch_issue && !resp_cnt) ? outst_q + ((outst_q != FULL) ? ONE : '0) :
                (!bus.fetch_issue && resp_cnt) ? outst_q - ONE : outst_q;
      count_d = bus.flush ? '0 : (enq && !deq) ? count_q + ONE : (!enq && deq) ? count_q - ONE : count_q;
      wr_ptr_d = bus.flush ? '0 : enq ? wr_ptr_q + PONE : wr_ptr_q;
      rd_ptr_d = bus.flush ? '0 : deq ? rd_ptr_q + PONE : rd_ptr_q;
      // on flush every fetch still in flight after this cycle is stale
      discard_d = bus.flush ? outst_d : (resp && discard_q != '0) ? discard_q - ONE : discard_q;
   end
   always_ff @(posedge clk) begin
      if (reset && enq) begin
         inst_mem_q[wr_ptr_q] <= bus.inst;
         pc_mem_q[wr_ptr_q] <= bus.inst_addr;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
         outst_q <= '0;
         discard_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
         outst_q <= outst_d;
         discard_q <= discard_d;
      end
   end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: scenario tasks with a scoreboard of expected head entries
module tb_inst_fetch_queue;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] sb_pc[$];
   logic [31:0] sb_inst[$];
   inst_fetch_queue_if bus();
   inst_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic drive(input logic iss, input logic iv, input logic [31:0] w, input logic [31:0] a,
                        input logic fl, input logic rdy);
      bus.fetch_issue = iss;
      bus.inst_valid = iv;
      bus.inst = w;
      bus.inst_addr = a;
      bus.flush = fl;
      bus.id_ready = rdy;
      #1;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      drive(1, 1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 1);
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", bus.id_valid); end
      n_cmp++; if (bus.fetch_allow !== 1'b0) begin n_err++; $display("FAIL rst_allow: got %b exp 0", bus.fetch_allow); end
      n_cmp++; if (bus.inst_read_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b exp 0", bus.inst_read_ready); end
      n_cmp++; if (bus.id_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h exp 0", bus.id_pc); end
      n_cmp++; if (bus.id_inst !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h exp 0", bus.id_inst); end
      tick();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      n_cmp++; if (bus.fetch_allow !== 1'b1) begin n_err++; $display("FAIL rel_allow: got %b exp 1", bus.fetch_allow); end
      n_cmp++; if (bus.inst_read_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b exp 1", bus.inst_read_ready); end
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL rel_valid: got %b exp 0", bus.id_valid); end
   endtask
   task automatic test_stream();
      for (int k = 0; k < 6; k++) begin
         logic iv;
         iv = (k >= 1) && (k <= 4);
         drive(k < 4, iv, 32'hA000_0000 + 32'(k - 1), 32'hBFC0_0000 + 32'(4 * (k - 1)), 0, 1);
         n_cmp++; if (bus.fetch_allow !== 1'b1) begin n_err++; $display("FAIL stream_allow k=%0d: got %b exp 1", k, bus.fetch_allow); end
         n_cmp++; if (bus.id_valid !== (sb_pc.size() != 0)) begin n_err++; $display("FAIL stream_valid k=%0d: got %b exp %b", k, bus.id_valid, sb_pc.size() != 0); end
         if (sb_pc.size() != 0) begin
            n_cmp++; if (bus.id_pc !== sb_pc[0]) begin n_err++; $display("FAIL stream_pc k=%0d: got %h exp %h", k, bus.id_pc, sb_pc[0]); end
            n_cmp++; if (bus.id_inst !== sb_inst[0]) begin n_err++; $display("FAIL stream_inst k=%0d: got %h exp %h", k, bus.id_inst, sb_inst[0]); end
         end
         if (iv) begin
            n_cmp++; if (bus.inst_read_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready k=%0d: got %b exp 1", k, bus.inst_read_ready); end
         end
         tick();
         if (sb_pc.size() != 0) begin
            void'(sb_pc.pop_front());
            void'(sb_inst.pop_front());
         end
         if (iv) begin
            sb_pc.push_back(32'hBFC0_0000 + 32'(4 * (k - 1)));
            sb_inst.push_back(32'hA000_0000 + 32'(k - 1));
         end
      end
      drive(0, 0, 0, 0, 0, 1);
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL stream_empty: got %b exp 0", bus.id_valid); end
   endtask
   task automatic test_backpressure();
      for (int k = 0; k < 5; k++) begin
         drive(k < 4, k >= 1, 32'hB000_0000 + 32'(k - 1), 32'h0000_1000 + 32'(4 * (k - 1)), 0, 0);
         n_cmp++; if (bus.fetch_allow !== (k < 4)) begin n_err++; $display("FAIL bp_allow k=%0d: got %b exp %b", k, bus.fetch_allow, k < 4); end
         if (k >= 1) begin
            n_cmp++; if (bus.inst_read_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready k=%0d: got %b exp 1", k, bus.inst_read_ready); end
         end
         tick();
         if (k >= 1) begin
            sb_pc.push_back(32'h0000_1000 + 32'(4 * (k - 1)));
            sb_inst.push_back(32'hB000_0000 + 32'(k - 1));
         end
      end
      for (int k = 0; k < 2; k++) begin
         drive(0, 1, 32'hB000_0004, 32'h0000_1010, 0, 0);
         n_cmp++; if (bus.inst_read_ready !== 1'b0) begin n_err++; $display("FAIL full_ready k=%0d: got %b exp 0", k, bus.inst_read_ready); end
         n_cmp++; if (bus.fetch_allow !== 1'b0) begin n_err++; $display("FAIL full_allow k=%0d: got %b exp 0", k, bus.fetch_allow); end
         n_cmp++; if (bus.id_pc !== sb_pc[0]) begin n_err++; $display("FAIL full_pc k=%0d: got %h exp %h", k, bus.id_pc, sb_pc[0]); end
         tick();
      end
      drive(0, 1, 32'hB000_0004, 32'h0000_1010, 0, 1);
      n_cmp++; if (bus.inst_read_ready !== 1'b0) begin n_err++; $display("FAIL full_deq_ready: got %b exp 0", bus.inst_read_ready); end
      n_cmp++; if (bus.id_inst !== sb_inst[0]) begin n_err++; $display("FAIL full_deq_inst: got %h exp %h", bus.id_inst, sb_inst[0]); end
      tick();
      void'(sb_pc.pop_front());
      void'(sb_inst.pop_front());
      drive(0, 1, 32'hB000_0004, 32'h0000_1010, 0, 0);
      n_cmp++; if (bus.inst_read_ready !== 1'b1) begin n_err++; $display("FAIL refill_ready: got %b exp 1", bus.inst_read_ready); end
      tick();
      sb_pc.push_back(32'h0000_1010);
      sb_inst.push_back(32'hB000_0004);
      drive(0, 0, 0, 0, 0, 0);
      n_cmp++; if (bus.inst_read_ready !== 1'b0) begin n_err++; $display("FAIL refull_ready: got %b exp 0", bus.inst_read_ready); end
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 0, 0, 1);
         n_cmp++; if (bus.id_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid k=%0d: got %b exp 1", k, bus.id_valid); end
         n_cmp++; if (bus.id_pc !== sb_pc[0]) begin n_err++; $display("FAIL drain_pc k=%0d: got %h exp %h", k, bus.id_pc, sb_pc[0]); end
         n_cmp++; if (bus.id_inst !== sb_inst[0]) begin n_err++; $display("FAIL drain_inst k=%0d: got %h exp %h", k, bus.id_inst, sb_inst[0]); end
         tick();
         void'(sb_pc.pop_front());
         void'(sb_inst.pop_front());
      end
      drive(0, 0, 0, 0, 0, 0);
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b exp 0", bus.id_valid); end
      n_cmp++; if (bus.fetch_allow !== 1'b1) begin n_err++; $display("FAIL drain_allow: got %b exp 1", bus.fetch_allow); end
   endtask
   task automatic test_flush();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(0, 1, 32'hC000_0000, 32'h0000_2000, 0, 0); tick();
      drive(0, 1, 32'hC000_0001, 32'h0000_2004, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 1, 1);
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b exp 0", bus.id_valid); end
      n_cmp++; if (bus.fetch_allow !== 1'b0) begin n_err++; $display("FAIL flush_allow: got %b exp 0", bus.fetch_allow); end
      tick();
      drive(0, 1, 32'h0000_1234, 32'h0000_3000, 0, 0);
      n_cmp++; if (bus.inst_read_ready !== 1'b1) begin n_err++; $display("FAIL drop1_ready: got %b exp 1", bus.inst_read_ready); end
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL drop1_valid: got %b exp 0", bus.id_valid); end
      tick();
      drive(0, 1, 32'h0000_5678, 32'h0000_3004, 0, 0);
      n_cmp++; if (bus.inst_read_ready !== 1'b1) begin n_err++; $display("FAIL drop2_ready: got %b exp 1", bus.inst_read_ready); end
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL drop2_valid: got %b exp 0", bus.id_valid); end
      tick();
      drive(1, 0, 0, 0, 0, 0);
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL drop_done_valid: got %b exp 0", bus.id_valid); end
      n_cmp++; if (bus.fetch_allow !== 1'b1) begin n_err++; $display("FAIL drop_done_allow: got %b exp 1", bus.fetch_allow); end
      tick();
      drive(0, 1, 32'h0000_9ABC, 32'h0000_3008, 0, 0);
      n_cmp++; if (bus.inst_read_ready !== 1'b1) begin n_err++; $display("FAIL keep_ready: got %b exp 1", bus.inst_read_ready); end
      tick();
      sb_pc.push_back(32'h0000_3008);
      sb_inst.push_back(32'h0000_9ABC);
      drive(0, 0, 0, 0, 0, 1);
      n_cmp++; if (bus.id_valid !== 1'b1) begin n_err++; $display("FAIL keep_valid: got %b exp 1", bus.id_valid); end
      n_cmp++; if (bus.id_inst !== sb_inst[0]) begin n_err++; $display("FAIL keep_inst: got %h exp %h", bus.id_inst, sb_inst[0]); end
      n_cmp++; if (bus.id_pc !== sb_pc[0]) begin n_err++; $display("FAIL keep_pc: got %h exp %h", bus.id_pc, sb_pc[0]); end
      tick();
      void'(sb_pc.pop_front());
      void'(sb_inst.pop_front());
      drive(0, 0, 0, 0, 0, 0);
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL keep_empty: got %b exp 0", bus.id_valid); end
   endtask
   task automatic test_flush_coincide();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 32'hDEAD_0001, 32'h0000_4000, 1, 0);
      n_cmp++; if (bus.fetch_allow !== 1'b0) begin n_err++; $display("FAIL coin_allow: got %b exp 0", bus.fetch_allow); end
      n_cmp++; if (bus.inst_read_ready !== 1'b1) begin n_err++; $display("FAIL coin_ready: got %b exp 1", bus.inst_read_ready); end
      tick();
      for (int d = 0; d < 2; d++) begin
         drive(0, 1, 32'hDEAD_0002 + 32'(d), 32'h0000_4004 + 32'(4 * d), 0, 0);
         n_cmp++; if (bus.inst_read_ready !== 1'b1) begin n_err++; $display("FAIL coin_drop_ready d=%0d: got %b exp 1", d, bus.inst_read_ready); end
         n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL coin_drop_valid d=%0d: got %b exp 0", d, bus.id_valid); end
         tick();
      end
      drive(1, 0, 0, 0, 0, 0);
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL coin_after_valid: got %b exp 0", bus.id_valid); end
      n_cmp++; if (bus.fetch_allow !== 1'b1) begin n_err++; $display("FAIL coin_after_allow: got %b exp 1", bus.fetch_allow); end
      tick();
      drive(0, 1, 32'hC0DE_0001, 32'h0000_4010, 0, 0);
      tick();
      sb_pc.push_back(32'h0000_4010);
      sb_inst.push_back(32'hC0DE_0001);
      drive(0, 0, 0, 0, 0, 1);
      n_cmp++; if (bus.id_valid !== 1'b1) begin n_err++; $display("FAIL coin_keep_valid: got %b exp 1", bus.id_valid); end
      n_cmp++; if (bus.id_inst !== sb_inst[0]) begin n_err++; $display("FAIL coin_keep_inst: got %h exp %h", bus.id_inst, sb_inst[0]); end
      tick();
      void'(sb_pc.pop_front());
      void'(sb_inst.pop_front());
      drive(0, 0, 0, 0, 0, 0);
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL coin_empty: got %b exp 0", bus.id_valid); end
   endtask
   task automatic test_reset_mid();
      for (int k = 0; k < 4; k++) begin drive(1, 0, 0, 0, 0, 0); tick(); end
      for (int k = 0; k < 3; k++) begin drive(0, 1, 32'hE000_0000 + 32'(k), 32'h0000_5000 + 32'(4 * k), 0, 0); tick(); end
      drive(1, 0, 0, 0, 0, 0); tick();
      reset = 1'b0;
      drive(0, 1, 32'hE000_00FF, 32'h0000_50FF, 1, 1);
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b exp 0", bus.id_valid); end
      n_cmp++; if (bus.fetch_allow !== 1'b0) begin n_err++; $display("FAIL mid_allow: got %b exp 0", bus.fetch_allow); end
      n_cmp++; if (bus.inst_read_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b exp 0", bus.inst_read_ready); end
      n_cmp++; if (bus.id_pc !== 32'h0) begin n_err++; $display("FAIL mid_pc: got %h exp 0", bus.id_pc); end
      tick();
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 0, 0, 0, 0);
         n_cmp++; if (bus.fetch_allow !== 1'b1) begin n_err++; $display("FAIL post_allow k=%0d: got %b exp 1", k, bus.fetch_allow); end
         n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL post_valid k=%0d: got %b exp 0", k, bus.id_valid); end
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, 32'hF000_0000 + 32'(k), 32'h0000_6000 + 32'(4 * k), 0, 0);
         n_cmp++; if (bus.inst_read_ready !== 1'b1) begin n_err++; $display("FAIL post_ready k=%0d: got %b exp 1", k, bus.inst_read_ready); end
         tick();
         sb_pc.push_back(32'h0000_6000 + 32'(4 * k));
         sb_inst.push_back(32'hF000_0000 + 32'(k));
      end
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 0, 0, 1);
         n_cmp++; if (bus.id_valid !== 1'b1) begin n_err++; $display("FAIL post_drain_valid k=%0d: got %b exp 1", k, bus.id_valid); end
         n_cmp++; if (bus.id_pc !== sb_pc[0]) begin n_err++; $display("FAIL post_drain_pc k=%0d: got %h exp %h", k, bus.id_pc, sb_pc[0]); end
         n_cmp++; if (bus.id_inst !== sb_inst[0]) begin n_err++; $display("FAIL post_drain_inst k=%0d: got %h exp %h", k, bus.id_inst, sb_inst[0]); end
         tick();
         void'(sb_pc.pop_front());
         void'(sb_inst.pop_front());
      end
      drive(0, 0, 0, 0, 0, 0);
      n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL post_empty: got %b exp 0", bus.id_valid); end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_flush_coincide();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
